// File: rtl/trap_filter_cfg.sv
// Runtime-configurable trapezoidal (pole-zero corrected) shaping filter.
// Samples enter a k/l tapped delay line, pass through a 4-stage arithmetic
// pipeline (d, p and M*d, s, saturate) and leave as a clipped unsigned value.
module trap_filter_cfg #(
    parameter int unsigned DATA_W    = 14,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned MAX_DEPTH = 64,
    parameter int unsigned M_W       = 10,
    parameter int unsigned ACC_W     = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [DATA_W-1:0]     in_data,
    input  logic                         cfg_we,
    input  logic [$clog2(MAX_DEPTH):0]   cfg_k,
    input  logic [$clog2(MAX_DEPTH):0]   cfg_l,
    input  logic [M_W-1:0]               cfg_m,
    output logic                         out_valid,
    output logic [OUT_W-1:0]             out_data,
    output logic                         sat_hi,
    output logic                         sat_lo,
    output logic                         cfg_err,
    output logic                         warm
);
    localparam int unsigned IDX_W = $clog2(MAX_DEPTH);
    localparam int unsigned CW    = IDX_W + 1;
    localparam int unsigned SW    = CW + 1;
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // Accumulator must hold the worst-case growth of the double integration
    if (ACC_W < DATA_W + M_W + 2*IDX_W + 3) begin : g_acc_w_check
        $error("trap_filter_cfg: ACC_W too narrow for DATA_W/M_W/MAX_DEPTH");
    end

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                    state, state_nxt;
    logic [CW-1:0]             fill_cnt, fill_nxt;
    logic [CW-1:0]             k_r, l_r, span;
    logic [M_W-1:0]            m_r;
    logic [SW-1:0]             k_sum;
    logic                      cfg_ok, accept;
    logic [IDX_W-1:0]          idx_k, idx_l, idx_kl;
    logic signed [DATA_W-1:0]  hist [MAX_DEPTH];
    logic signed [DATA_W-1:0]  tx, txk, txl, txkl;
    logic signed [ACC_W-1:0]   m_ext, d_r, p_r, md_r, s_r;
    logic                      v0, v1, v2, v3;
    logic                      t0, t1, t2, t3;

    // Write validation and sample acceptance (a config write always drops the sample)
    assign k_sum  = {1'b0, cfg_k} + {1'b0, cfg_l};
    assign cfg_ok = cfg_we && (cfg_k != '0) && (cfg_k <= cfg_l) && (k_sum <= SW'(MAX_DEPTH));
    assign accept = in_valid && !cfg_we;

    // Tap addresses into the history: hist[i] is the sample accepted i+1 samples ago
    assign span   = k_r + l_r;
    assign idx_k  = IDX_W'(k_r - CW'(1));
    assign idx_l  = IDX_W'(l_r - CW'(1));
    assign idx_kl = IDX_W'(span - CW'(1));
    assign m_ext  = ACC_W'(m_r);

    // Configuration registers and sticky write-error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            k_r     <= CW'(4);
            l_r     <= CW'(8);
            m_r     <= '0;
            cfg_err <= 1'b0;
        end else if (cfg_we) begin
            if (cfg_ok) begin
                k_r     <= cfg_k;
                l_r     <= cfg_l;
                m_r     <= cfg_m;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    // FSM state register, fill counter and registered warm flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            fill_cnt <= '0;
            warm     <= 1'b0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_nxt;
            warm     <= (state_nxt == FILL);
        end
    end

    // Next-state: first sample opens FILL, k+l further samples reach RUN
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = FILL;
                    fill_nxt  = '0;
                end
            end
            FILL: begin
                if (accept) begin
                    fill_nxt = fill_cnt + CW'(1);
                    if (fill_cnt == span - CW'(1)) begin
                        state_nxt = RUN;
                        fill_nxt  = '0;
                    end
                end
            end
            default: begin
            end
        endcase
        if (cfg_ok) begin
            state_nxt = IDLE;
            fill_nxt  = '0;
        end
    end

    // Delay line shifts only on accepted samples
    always_ff @(posedge clk) begin
        if (!reset || cfg_ok) begin
            for (int i = 0; i < int'(MAX_DEPTH); i++) hist[i] <= '0;
        end else if (accept) begin
            hist[0] <= in_data;
            for (int i = 1; i < int'(MAX_DEPTH); i++) hist[i] <= hist[i-1];
        end
    end

    // Tap capture, d, p / M*d and s stages; v marks real samples, t marks samples owed an output
    always_ff @(posedge clk) begin
        if (!reset || cfg_ok) begin
            {v0, v1, v2, v3} <= '0;
            {t0, t1, t2, t3} <= '0;
            tx   <= '0;
            txk  <= '0;
            txl  <= '0;
            txkl <= '0;
            d_r  <= '0;
            p_r  <= '0;
            md_r <= '0;
            s_r  <= '0;
        end else begin
            v0 <= accept;
            t0 <= accept && (state == RUN);
            if (accept) begin
                tx   <= in_data;
                txk  <= hist[idx_k];
                txl  <= hist[idx_l];
                txkl <= hist[idx_kl];
            end
            v1 <= v0;
            t1 <= t0;
            if (v0) d_r <= ACC_W'(tx) - ACC_W'(txk) - ACC_W'(txl) + ACC_W'(txkl);
            v2 <= v1;
            t2 <= t1;
            if (v1) begin
                p_r  <= p_r + d_r;
                md_r <= d_r * m_ext;
            end
            v3 <= v2;
            t3 <= t2;
            if (v2) s_r <= s_r + p_r + md_r;
        end
    end

    // Saturating output stage; flags only accompany out_valid
    always_ff @(posedge clk) begin
        if (!reset || cfg_ok) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
        end else begin
            out_valid <= v3 && t3;
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
            if (v3 && t3) begin
                if (s_r[ACC_W-1]) begin
                    out_data <= '0;
                    sat_lo   <= 1'b1;
                end else if (s_r > OUT_MAX) begin
                    out_data <= '1;
                    sat_hi   <= 1'b1;
                end else begin
                    out_data <= s_r[OUT_W-1:0];
                end
            end
        end
    end

endmodule
